// File: rtl/ins_encoder_loader_pkg.sv
// Shared definitions for the RV32I instruction encoder/loader: format codes,
// loader FSM states and base opcode constants.
package ins_encoder_loader_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_LOAD = 7'h03;
    localparam logic [6:0] OP_S    = 7'h23;
    localparam logic [6:0] OP_B    = 7'h63;
    localparam logic [6:0] OP_LUI  = 7'h37;
    localparam logic [6:0] OP_JAL  = 7'h6F;

endpackage

// File: rtl/ins_encoder_loader_packer.sv
// Combinational RV32I field packer: builds the 32-bit instruction word from
// decoded fields and flags format codes that have no encoding.
module ins_packer
    import ins_encoder_loader_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            // Branch and jump offsets are even; bit 0 is silently dropped.
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ins_encoder_loader.sv
// Instruction-memory loader: accepts field tuples, packs them into RV32I words
// and writes them to consecutive word addresses over a valid/ready port.
module ins_encoder_loader
    import ins_encoder_loader_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              last,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] COUNT_DEPTH = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] index_reg;
    logic [ADDR_W:0]   count_reg;
    logic [31:0]       addr_reg, wdata_reg;
    logic              err_reg, last_reg;

    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              accept, wr_done, start_ok, hit_depth;
    logic [ADDR_W:0]   count_inc;

    ins_packer u_packer (
        .fmt     (fmt),
        .opcode  (opcode),
        .rd      (rd),
        .funct3  (funct3),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct7  (funct7),
        .imm     (imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign accept    = (state_reg == ST_LOAD) && in_valid;
    assign wr_done   = (state_reg == ST_WRITE) && mem_ready;
    assign start_ok  = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && start;
    assign count_inc = count_reg + 1'b1;
    assign hit_depth = (count_inc == COUNT_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
            ST_LOAD: begin
                if (in_valid) begin
                    if (!enc_illegal)  state_next = ST_WRITE;
                    else if (last)     state_next = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (mem_ready) state_next = (last_reg || hit_depth) ? ST_DONE : ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_reg <= '0;
            count_reg <= '0;
            addr_reg  <= BASE_ADDR;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            if (start_ok) begin
                index_reg <= '0;
                count_reg <= '0;
                err_reg   <= 1'b0;
            end
            if (accept) begin
                if (enc_illegal) begin
                    err_reg <= 1'b1;
                end else begin
                    wdata_reg <= enc_word;
                    addr_reg  <= BASE_ADDR + (32'(index_reg) << 2);
                    last_reg  <= last;
                end
            end
            if (wr_done) begin
                index_reg <= index_reg + 1'b1;
                count_reg <= count_inc;
                // Running out of room before the final tuple is an overflow.
                if (hit_depth && !last_reg) err_reg <= 1'b1;
            end
        end
    end

    assign in_ready  = (state_reg == ST_LOAD);
    assign mem_we    = (state_reg == ST_WRITE);
    assign busy      = (state_reg == ST_LOAD) || (state_reg == ST_WRITE);
    assign done      = (state_reg == ST_DONE);
    assign err       = err_reg;
    assign count     = count_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_ins_encoder_loader.sv
// Self-checking bench for ins_encoder_loader: directed program load, stalls,
// illegal formats, overflow, reset, plus randomized sessions against a model.
module tb_ins_encoder_loader;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } tup_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        in_valid = 1'b0, last = 1'b0, mem_ready = 1'b0;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] imm = '0;

    logic        in_ready_a, mem_we_a, busy_a, done_a, err_a;
    logic [31:0] mem_addr_a, mem_wdata_a;
    logic [8:0]  count_a;
    logic        in_ready_b, mem_we_b, busy_b, done_b, err_b;
    logic [31:0] mem_addr_b, mem_wdata_b;
    logic [2:0]  count_b;

    bit          sel = 1'b0;
    logic        in_ready_o, mem_we_o, busy_o, done_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, count_o;

    int n_tests = 0;
    int n_fail  = 0;
    int writes_seen = 0;
    int m_cnt = 0;
    int m_depth = 256;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    ins_encoder_loader dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .last(last), .mem_we(mem_we_a), .mem_ready(mem_ready),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .count(count_a), .busy(busy_a),
        .done(done_a), .err(err_a)
    );

    ins_encoder_loader #(.ADDR_W(2), .DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .last(last), .mem_we(mem_we_b), .mem_ready(mem_ready),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .count(count_b), .busy(busy_b),
        .done(done_b), .err(err_b)
    );

    assign in_ready_o  = sel ? in_ready_b  : in_ready_a;
    assign mem_we_o    = sel ? mem_we_b    : mem_we_a;
    assign busy_o      = sel ? busy_b      : busy_a;
    assign done_o      = sel ? done_b      : done_a;
    assign err_o       = sel ? err_b       : err_a;
    assign mem_addr_o  = sel ? mem_addr_b  : mem_addr_a;
    assign mem_wdata_o = sel ? mem_wdata_b : mem_wdata_a;
    assign count_o     = sel ? 32'(count_b) : 32'(count_a);

    always @(negedge clk) begin
        if (!reset && mem_we_o && mem_ready) writes_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoding built from shifted fields, straight from the format tables.
    function automatic logic [31:0] model_enc(input tup_t t, output bit bad);
        logic [31:0] im;
        logic [31:0] low;
        im  = t.imm;
        low = 32'(t.op);
        bad = 1'b0;
        case (t.fmt)
            3'd0: return (32'(t.f7) << 25) | (32'(t.rs2) << 20) | (32'(t.rs1) << 15)
                       | (32'(t.f3) << 12) | (32'(t.rd) << 7) | low;
            3'd1: return ((im & 32'hFFF) << 20) | (32'(t.rs1) << 15) | (32'(t.f3) << 12)
                       | (32'(t.rd) << 7) | low;
            3'd2: return (((im >> 5) & 32'h7F) << 25) | (32'(t.rs2) << 20) | (32'(t.rs1) << 15)
                       | (32'(t.f3) << 12) | ((im & 32'h1F) << 7) | low;
            3'd3: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                       | (32'(t.rs2) << 20) | (32'(t.rs1) << 15) | (32'(t.f3) << 12)
                       | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | low;
            3'd4: return (im & 32'hFFFF_F000) | (32'(t.rd) << 7) | low;
            3'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                       | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                       | (32'(t.rd) << 7) | low;
            default: begin
                bad = 1'b1;
                return 32'h0;
            end
        endcase
    endfunction

    task automatic drive(input tup_t t, input bit lst);
        fmt = t.fmt; opcode = t.op; rd = t.rd; funct3 = t.f3;
        rs1 = t.rs1; rs2 = t.rs2; funct7 = t.f7; imm = t.imm; last = lst;
        in_valid = 1'b1;
    endtask

    task automatic start_session();
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    // Offer one tuple, then (if legal) hold the write for 'stall' cycles before mem_ready.
    task automatic put(input tup_t t, input bit lst, input int stall,
                       input bit use_golden, input logic [31:0] golden);
        logic [31:0] exp_w, exp_a;
        bit bad;
        int w;
        drive(t, lst);
        w = 0;
        while (!in_ready_o && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready_o) begin
            chk("accept_timeout", 32'(in_ready_o), 32'd1);
            in_valid = 1'b0;
            return;
        end
        exp_w = model_enc(t, bad);
        if (use_golden) exp_w = golden;
        @(posedge clk); #1;
        in_valid = 1'b0;
        last = 1'b0;
        if (bad) begin
            m_err = 1'b1;
            chk("illegal_no_we", 32'(mem_we_o), 32'd0);
            $display("[TB] illegal fmt=%0d dropped", t.fmt);
            return;
        end
        exp_a = 32'(m_cnt) << 2;
        for (int i = 0; i <= stall; i++) begin
            chk("mem_we", 32'(mem_we_o), 32'd1);
            chk("mem_addr", mem_addr_o, exp_a);
            chk("mem_wdata", mem_wdata_o, exp_w);
            chk("in_ready_in_write", 32'(in_ready_o), 32'd0);
            if (i == stall) mem_ready = 1'b1;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        m_cnt++;
        if (m_cnt == m_depth && !lst) m_err = 1'b1;
        $display("[TB] write addr=%h data=%h stall=%0d", exp_a, exp_w, stall);
    endtask

    task automatic end_chk(input string tag);
        chk({tag, "_count"}, count_o, 32'(m_cnt));
        chk({tag, "_err"}, 32'(err_o), 32'(m_err));
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    tup_t        prog [6];
    logic [31:0] gold [6];

    initial begin
        tup_t t;
        int   n, base_w;

        prog[0] = '{3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0};
        prog[1] = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5};
        prog[2] = '{3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8};
        prog[3] = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC};
        prog[4] = '{3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000};
        prog[5] = '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8};
        gold[0] = 32'h002081B3; gold[1] = 32'h00500093; gold[2] = 32'h0020A423;
        gold[3] = 32'hFE208EE3; gold[4] = 32'h123452B7; gold[5] = 32'h008000EF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        chk("rst_count", count_o, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reference program, no stalls.
        start_session();
        for (int i = 0; i < 6; i++) put(prog[i], i == 5, 0, 1'b1, gold[i]);
        end_chk("prog");

        // Backpressure plus a start pulse while the session is busy.
        start_session();
        put(prog[0], 1'b0, 0, 1'b0, 32'h0);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("busy_start_count", count_o, 32'd1);
        chk("busy_start_busy", 32'(busy_o), 32'd1);
        put(prog[1], 1'b1, 3, 1'b0, 32'h0);
        end_chk("stall");

        // Illegal format between two legal tuples.
        start_session();
        put(prog[0], 1'b0, 0, 1'b0, 32'h0);
        t = prog[2]; t.fmt = 3'd6;
        put(t, 1'b0, 0, 1'b0, 32'h0);
        put(prog[4], 1'b1, 0, 1'b0, 32'h0);
        end_chk("illegal");

        // New start after a failed session clears err and count.
        start_session();
        chk("restart_err", 32'(err_o), 32'd0);
        chk("restart_count", count_o, 32'd0);
        chk("restart_done", 32'(done_o), 32'd0);
        put(prog[1], 1'b0, 0, 1'b0, 32'h0);
        drive(prog[2], 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_reset_we", 32'(mem_we_o), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midwrite_rst_we", 32'(mem_we_o), 32'd0);
        chk("midwrite_rst_busy", 32'(busy_o), 32'd0);
        chk("midwrite_rst_done", 32'(done_o), 32'd0);
        chk("midwrite_rst_count", count_o, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Overflow on the four-word instance.
        sel = 1'b1;
        m_depth = 4;
        start_session();
        base_w = writes_seen;
        for (int i = 0; i < 4; i++) put(prog[i], 1'b0, i % 2, 1'b0, 32'h0);
        drive(prog[4], 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("ovf_fifth_ready", 32'(in_ready_o), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("ovf_writes", 32'(writes_seen - base_w), 32'd4);
        end_chk("ovf");
        sel = 1'b0;
        m_depth = 256;

        // Randomized sessions.
        for (int s = 0; s < 6; s++) begin
            start_session();
            base_w = writes_seen;
            n = $urandom_range(3, 10);
            for (int k = 0; k < n; k++) begin
                t.fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
                t.op  = 7'($urandom); t.rd  = 5'($urandom); t.f3 = 3'($urandom);
                t.rs1 = 5'($urandom); t.rs2 = 5'($urandom); t.f7 = 7'($urandom);
                t.imm = $urandom;
                put(t, k == n - 1, $urandom_range(0, 2), 1'b0, 32'h0);
            end
            chk("rand_writes", 32'(writes_seen - base_w), 32'(m_cnt));
            end_chk("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
